// File: rtl/llc_mem_line_packer.sv
// LLC <-> word-bus line packer: serializes write-back lines into word beats and
// reassembles read data words into a full line response. One transaction in flight.

module llc_mem_line_packer_lane #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_word
);
  logic [WORD_W-1:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_word <= '0;
    else if (i_we) r_word <= i_data;
  end

  assign o_word = r_word;
endmodule

module llc_mem_line_packer #(
  parameter int WORD_W   = 32,
  parameter int WORDS    = 4,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       llc_mem_req_valid,
  output logic                       llc_mem_req_ready,
  input  logic                       llc_mem_req_hwrite,
  input  logic [2:0]                 llc_mem_req_hsize,
  input  logic [1:0]                 llc_mem_req_hprot,
  input  logic [ADDR_W-OFFSET_W-1:0] llc_mem_req_addr,
  input  logic [WORDS*WORD_W-1:0]    llc_mem_req_line,
  output logic                       llc_mem_rsp_valid,
  input  logic                       llc_mem_rsp_ready,
  output logic [WORDS*WORD_W-1:0]    llc_mem_rsp_line,
  output logic                       bus_req_valid,
  input  logic                       bus_req_ready,
  output logic                       bus_req_write,
  output logic [ADDR_W-1:0]          bus_req_addr,
  output logic [2:0]                 bus_req_hsize,
  output logic [1:0]                 bus_req_hprot,
  output logic [WORD_W-1:0]          bus_req_wdata,
  output logic                       bus_req_last,
  input  logic                       bus_rsp_valid,
  output logic                       bus_rsp_ready,
  input  logic [WORD_W-1:0]          bus_rsp_data
);
  localparam int CNT_W   = $clog2(WORDS);
  localparam int BYTE_SH = $clog2(WORD_W/8);

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
  logic [2:0]                      r_hsize;
  logic [1:0]                      r_hprot;
  logic [ADDR_W-OFFSET_W-1:0]      r_addr;
  logic [WORDS-1:0][WORD_W-1:0]    r_line;
  logic [WORDS-1:0][WORD_W-1:0]    w_rsp_words;
  logic [WORDS-1:0]                w_lane_we;
  logic [OFFSET_W-1:0]             w_off;
  logic                            w_last;
  logic                            w_accept;

  assign w_last   = (r_cnt == CNT_W'(WORDS-1));
  assign w_accept = (r_state == IDLE) && llc_mem_req_valid;
  // Beat offset lives only in the offset field, so it can never carry into the line address.
  assign w_off    = OFFSET_W'(r_cnt) << BYTE_SH;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    llc_mem_req_ready = 1'b0;
    llc_mem_rsp_valid = 1'b0;
    bus_req_valid     = 1'b0;
    bus_req_write     = 1'b0;
    bus_req_addr      = '0;
    bus_req_wdata     = '0;
    bus_req_last      = 1'b0;
    bus_rsp_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        llc_mem_req_ready = 1'b1;
        if (llc_mem_req_valid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = llc_mem_req_hwrite ? WR_BEAT : RD_ADDR;
        end
      end
      WR_BEAT: begin
        bus_req_valid = 1'b1;
        bus_req_write = 1'b1;
        bus_req_addr  = {r_addr, w_off};
        bus_req_wdata = r_line[r_cnt];
        bus_req_last  = w_last;
        if (bus_req_ready) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      RD_ADDR: begin
        bus_req_valid = 1'b1;
        bus_req_addr  = {r_addr, {OFFSET_W{1'b0}}};
        bus_req_last  = 1'b1;
        if (bus_req_ready) begin
          w_state_nxt = RD_DATA;
          w_cnt_nxt   = '0;
        end
      end
      RD_DATA: begin
        bus_rsp_ready = 1'b1;
        if (bus_rsp_valid) begin
          if (w_last) begin
            w_state_nxt = RSP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      RSP: begin
        llc_mem_rsp_valid = 1'b1;
        if (llc_mem_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hsize <= '0;
      r_hprot <= '0;
      r_addr  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_hsize <= llc_mem_req_hsize;
        r_hprot <= llc_mem_req_hprot;
        r_addr  <= llc_mem_req_addr;
        r_line  <= llc_mem_req_line;
      end
    end
  end

  // Response line is one register per word; reset clears it so an aborted read leaves nothing behind.
  for (genvar i = 0; i < WORDS; i++) begin : g_lane
    assign w_lane_we[i] = (r_state == RD_DATA) && bus_rsp_valid && (r_cnt == CNT_W'(i));
    llc_mem_line_packer_lane #(.WORD_W(WORD_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_lane_we[i]),
      .i_data (bus_rsp_data),
      .o_word (w_rsp_words[i])
    );
  end

  assign llc_mem_rsp_line = w_rsp_words;
  assign bus_req_hsize    = r_hsize;
  assign bus_req_hprot    = r_hprot;
endmodule

// File: tb/tb_llc_mem_line_packer.sv
// Bench for llc_mem_line_packer: vector table plus scoreboard of expected bus beats and line responses.
module tb_llc_mem_line_packer;
  localparam int WORD_W = 32, WORDS = 4, ADDR_W = 32, OFFSET_W = 4;
  localparam int LW = WORDS*WORD_W, LA = ADDR_W-OFFSET_W;

  logic clk = 1'b0, rst = 1'b1;
  logic llc_mem_req_valid, llc_mem_req_ready, llc_mem_req_hwrite;
  logic [2:0] llc_mem_req_hsize;
  logic [1:0] llc_mem_req_hprot;
  logic [LA-1:0] llc_mem_req_addr;
  logic [LW-1:0] llc_mem_req_line, llc_mem_rsp_line;
  logic llc_mem_rsp_valid, llc_mem_rsp_ready;
  logic bus_req_valid, bus_req_ready, bus_req_write, bus_req_last;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [2:0] bus_req_hsize;
  logic [1:0] bus_req_hprot;
  logic [WORD_W-1:0] bus_req_wdata, bus_rsp_data;
  logic bus_rsp_valid, bus_rsp_ready;

  llc_mem_line_packer #(.WORD_W(WORD_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_hwrite(llc_mem_req_hwrite), .llc_mem_req_hsize(llc_mem_req_hsize),
    .llc_mem_req_hprot(llc_mem_req_hprot), .llc_mem_req_addr(llc_mem_req_addr),
    .llc_mem_req_line(llc_mem_req_line),
    .llc_mem_rsp_valid(llc_mem_rsp_valid), .llc_mem_rsp_ready(llc_mem_rsp_ready),
    .llc_mem_rsp_line(llc_mem_rsp_line),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
    .bus_req_addr(bus_req_addr), .bus_req_hsize(bus_req_hsize), .bus_req_hprot(bus_req_hprot),
    .bus_req_wdata(bus_req_wdata), .bus_req_last(bus_req_last),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready), .bus_rsp_data(bus_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              wr;
    logic              last;
    logic [2:0]        hs;
    logic [1:0]        hp;
  } beat_t;

  typedef struct {
    logic          wr;
    logic [LA-1:0] a;
    logic [LW-1:0] ln;
    logic [2:0]    hs;
    logic [1:0]    hp;
    int            e_rdy;
    int            e_rsp;
  } vec_t;

  beat_t             q_beat[$];
  logic [LW-1:0]     q_rsp[$];
  logic [WORD_W-1:0] q_rd[$];
  int checks = 0, errors = 0;
  logic tog = 1'b0, spur = 1'b0;
  int rsp_hold = 0, n_taken = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Bus read-data source: presents queued words, pops on each observed handshake.
  initial begin : responder
    bit take;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    forever begin
      @(negedge clk);
      take = bus_rsp_valid && bus_rsp_ready && !rst;
      @(posedge clk); #1;
      if (rst) q_rd.delete();
      else if (take && q_rd.size() > 0) begin
        void'(q_rd.pop_front());
        n_taken++;
      end
      bus_rsp_valid = spur || (q_rd.size() > 0);
      bus_rsp_data  = (q_rd.size() > 0) ? q_rd[0] : 32'hBAD0BAD0;
    end
  end

  initial begin : rdy_drv
    int held = 0;
    bus_req_ready     = 1'b1;
    llc_mem_rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus_req_ready     = tog ? ~bus_req_ready : 1'b1;
      held              = llc_mem_rsp_valid ? held + 1 : 0;
      llc_mem_rsp_ready = (held > rsp_hold);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        q_beat.delete();
        q_rsp.delete();
      end else begin
        if (bus_req_valid) begin
          if (q_beat.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected got addr=%h want none", bus_req_addr);
          end else begin
            chk("beat_addr", LW'(bus_req_addr), LW'(q_beat[0].addr));
            chk("beat_wdata", LW'(bus_req_wdata), LW'(q_beat[0].wdata));
            chk("beat_ctrl", LW'({bus_req_write, bus_req_last, bus_req_hsize, bus_req_hprot}),
                LW'({q_beat[0].wr, q_beat[0].last, q_beat[0].hs, q_beat[0].hp}));
            if (bus_req_ready) void'(q_beat.pop_front());
          end
        end
        if (spur) chk("spur_rsp_ready", LW'(bus_rsp_ready), LW'(0));
        if (llc_mem_rsp_valid) begin
          if (q_rsp.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected got=%h want none", llc_mem_rsp_line);
          end else begin
            chk("rsp_line", llc_mem_rsp_line, q_rsp[0]);
            if (llc_mem_rsp_ready) void'(q_rsp.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [LA-1:0] a, input logic [LW-1:0] ln,
                       input logic [2:0] hs, input logic [1:0] hp);
    logic [ADDR_W-1:0] base;
    bit ok;
    base = {a, 4'h0};
    if (wr) begin
      for (int i = 0; i < WORDS; i++)
        q_beat.push_back('{base | ADDR_W'(i*4), ln[i*WORD_W +: WORD_W], 1'b1, (i == WORDS-1), hs, hp});
    end else begin
      q_beat.push_back('{base, '0, 1'b0, 1'b1, hs, hp});
      for (int i = 0; i < WORDS; i++) q_rd.push_back(ln[i*WORD_W +: WORD_W]);
      q_rsp.push_back(ln);
    end
    @(posedge clk); #1;
    llc_mem_req_valid  = 1'b1;
    llc_mem_req_hwrite = wr;
    llc_mem_req_addr   = a;
    llc_mem_req_line   = ln;
    llc_mem_req_hsize  = hs;
    llc_mem_req_hprot  = hp;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = llc_mem_req_ready;
    end
    if (!ok) begin checks++; errors++; $display("FAIL req_accept_timeout got=0 want=1"); end
    @(posedge clk); #1;
    // Scramble the request bus so only latched values can reach the beats.
    llc_mem_req_valid = 1'b0;
    llc_mem_req_addr  = ~a;
    llc_mem_req_line  = ~ln;
    llc_mem_req_hsize = ~hs;
    llc_mem_req_hprot = ~hp;
  endtask

  // Counts cycles after the accept edge until ready returns (lat_rdy) and rsp_valid first rises (lat_rsp).
  task automatic finish(output int lat_rdy, output int lat_rsp);
    bit ok;
    lat_rdy = -1;
    lat_rsp = -1;
    ok = 1'b0;
    for (int n = 1; n <= 200 && !ok; n++) begin
      @(negedge clk);
      if (llc_mem_rsp_valid && lat_rsp < 0) lat_rsp = n;
      if (llc_mem_req_ready) begin ok = 1'b1; lat_rdy = n; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL done_timeout got=busy want=idle"); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin : main
    vec_t tv[6];
    int lr, lp, base_taken;
    bit ok;
    tv[0] = '{1'b1, 28'h0000010, 128'hDDDDCCCC_BBBBAAAA_99998888_77776666, 3'd2, 2'd1, 5, -1};
    tv[1] = '{1'b0, 28'h0000020, 128'h00000004_00000003_00000002_00000001, 3'd2, 2'd3, 7, 6};
    tv[2] = '{1'b1, 28'hFFFFFFF, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 3'd1, 2'd0, 5, -1};
    tv[3] = '{1'b0, 28'hFFFFFFF, 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF, 3'd2, 2'd2, 7, 6};
    tv[4] = '{1'b1, 28'h1234567, 128'h11112222_33334444_55556666_77778888, 3'd0, 2'd1, 5, -1};
    tv[5] = '{1'b0, 28'h0ABCDEF, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000, 3'd2, 2'd1, 7, 6};

    llc_mem_req_valid = 1'b0; llc_mem_req_hwrite = 1'b0; llc_mem_req_hsize = '0;
    llc_mem_req_hprot = '0;   llc_mem_req_addr = '0;    llc_mem_req_line = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", LW'(llc_mem_req_ready), LW'(1));
    chk("rst_bus_valids", LW'({bus_req_valid, bus_rsp_ready, llc_mem_rsp_valid}), LW'(0));
    chk("rst_bus_fields", LW'({bus_req_write, bus_req_addr, bus_req_hsize, bus_req_hprot, bus_req_wdata, bus_req_last}), LW'(0));
    chk("rst_rsp_line", llc_mem_rsp_line, '0);
    @(posedge clk); #3 rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      issue(tv[k].wr, tv[k].a, tv[k].ln, tv[k].hs, tv[k].hp);
      finish(lr, lp);
      chk($sformatf("vec%0d_ready_lat", k), LW'(lr), LW'(tv[k].e_rdy));
      chk($sformatf("vec%0d_rsp_lat", k), LW'(lp), LW'(tv[k].e_rsp));
    end

    // Bus request backpressure during a write: toggling ready.
    tog = 1'b1;
    issue(1'b1, 28'h0000040, 128'h44444444_33333333_22222222_11111111, 3'd2, 2'd2);
    finish(lr, lp);
    tog = 1'b0;
    chk("bp_write_all_beats", LW'(q_beat.size()), LW'(0));

    // Response held off for 5 cycles: line must stay put until accepted.
    rsp_hold = 5;
    issue(1'b0, 28'h0000050, 128'h89ABCDEF_76543210_FEDCBA98_01234567, 3'd2, 2'd0);
    finish(lr, lp);
    rsp_hold = 0;
    chk("bp_rsp_ready_lat", LW'(lr), LW'(12));
    chk("bp_rsp_valid_lat", LW'(lp), LW'(6));

    // Spurious read data while idle and during a write.
    spur = 1'b1;
    repeat (4) @(posedge clk);
    issue(1'b1, 28'h0000060, 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, 3'd2, 2'd1);
    finish(lr, lp);
    chk("spur_ready_lat", LW'(lr), LW'(5));
    spur = 1'b0;
    #1;
    chk("spur_rsp_line_kept", llc_mem_rsp_line, 128'h89ABCDEF_76543210_FEDCBA98_01234567);
    repeat (2) @(posedge clk);

    // Reset after the second read data beat aborts the read.
    base_taken = n_taken;
    issue(1'b0, 28'h0000070, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 3'd2, 2'd3);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = (n_taken >= base_taken + 2);
    end
    if (!ok) begin checks++; errors++; $display("FAIL abort_wait got=%0d want=%0d", n_taken - base_taken, 2); end
    rst = 1'b1;
    #1;
    chk("abort_req_ready", LW'(llc_mem_req_ready), LW'(1));
    chk("abort_valids", LW'({bus_req_valid, bus_rsp_ready, llc_mem_rsp_valid}), LW'(0));
    chk("abort_bus_fields", LW'({bus_req_write, bus_req_addr, bus_req_hsize, bus_req_hprot, bus_req_wdata, bus_req_last}), LW'(0));
    chk("abort_rsp_line", llc_mem_rsp_line, '0);
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b0;
    issue(1'b0, 28'h0000080, 128'h44444444_33333333_22222222_11111111, 3'd2, 2'd3);
    finish(lr, lp);
    chk("post_abort_rsp_lat", LW'(lp), LW'(6));
    chk("post_abort_line_held", llc_mem_rsp_line, 128'h44444444_33333333_22222222_11111111);

    repeat (3) @(posedge clk);
    #1;
    chk("end_beats_drained", LW'(q_beat.size()), LW'(0));
    chk("end_rsps_drained", LW'(q_rsp.size()), LW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/llc_mem_line_packer.md
# llc_mem_line_packer

Sits between the LLC and the word-wide memory bus. Accepts one line-wide LLC memory request (read or write-back), serializes write lines into word beats with per-beat byte addresses, and for reads issues one address beat then reassembles returning data words into a full line response for the LLC. One transaction is outstanding at a time; all upstream and downstream channels use valid/ready handshakes.

## Interface
- WORD_W, 32, bits per word (`BITS_PER_WORD`)
- WORDS, 4, words per line, power of two ≥ 2 (`WORDS_PER_LINE`)
- ADDR_W, 32, byte address width (`ADDR_BITS`)
- OFFSET_W, 4, line offset bits, = log2(WORDS·WORD_W/8) (`OFFSET_BITS`)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- llc_mem_req_valid  in  1  LLC request valid
- llc_mem_req_ready  out  1  block can accept a request
- llc_mem_req_hwrite  in  1  1 = write-back line, 0 = line read
- llc_mem_req_hsize  in  3  transfer size, forwarded per beat
- llc_mem_req_hprot  in  2  protection, forwarded per beat
- llc_mem_req_addr  in  ADDR_W-OFFSET_W  line address
- llc_mem_req_line  in  WORDS·WORD_W  write data, word i at [i·WORD_W +: WORD_W]
- llc_mem_rsp_valid  out  1  assembled read line valid
- llc_mem_rsp_ready  in  1  LLC accepts response
- llc_mem_rsp_line  out  WORDS·WORD_W  assembled line, same word ordering
- bus_req_valid / bus_req_ready  out / in  1  bus request handshake
- bus_req_write  out  1  beat is a write
- bus_req_addr  out  ADDR_W  byte address of beat
- bus_req_hsize  out  3, bus_req_hprot  out  2  latched from request
- bus_req_wdata  out  WORD_W  write data of beat
- bus_req_last  out  1  final beat of this request
- bus_rsp_valid / bus_rsp_ready  in / out  1  read data handshake
- bus_rsp_data  in  WORD_W  read data word

## Operation
- FSM states: IDLE, WR_BEAT, RD_ADDR, RD_DATA, RSP.
- IDLE: llc_mem_req_ready=1. On valid&ready latch hwrite, hsize, hprot, addr, line; clear beat counter cnt (log2 WORDS bits); go WR_BEAT if hwrite else RD_ADDR.
- WR_BEAT: bus_req_valid=1, write=1, addr = {line_addr, OFFSET_W'0} + cnt·(WORD_W/8), wdata = latched word cnt, last = (cnt==WORDS-1). On handshake: if last → IDLE, else cnt++. Writes are posted; no response expected.
- RD_ADDR: bus_req_valid=1, write=0, addr = line base, wdata=0, last=1. On handshake → RD_DATA, cnt=0.
- RD_DATA: bus_rsp_ready=1. On handshake store bus_rsp_data into word cnt of response register; at cnt==WORDS-1 → RSP, else cnt++.
- RSP: llc_mem_rsp_valid=1, line held stable; on llc_mem_rsp_ready → IDLE.
- bus_rsp_ready=0 outside RD_DATA; bus_rsp_valid there is not consumed and does not affect state.
- Outputs in any state are held stable while valid and not ready.
- Address arithmetic modulo 2^ADDR_W; beat addresses never cross the line (offset field only).

## Timing
- Reset (asynchronous assert, sampled release): state=IDLE, cnt=0, llc_mem_req_ready=1, llc_mem_rsp_valid=0, llc_mem_rsp_line=0, bus_req_valid=0, bus_req_write=0, bus_req_addr=0, bus_req_hsize=0, bus_req_hprot=0, bus_req_wdata=0, bus_req_last=0, bus_rsp_ready=0. Reset mid-transaction aborts it; no partial response is ever emitted.
- llc_mem_req_ready is registered-state driven: low from the cycle after acceptance until the cycle after the final handshake (write last beat, or rsp accept).
- Write, bus_req_ready always 1: accept at edge 0, beats in cycles 1..WORDS, ready high in cycle WORDS+1.
- Read, both buses always ready, data returned back-to-back: accept edge 0, address beat cycle 1, data cycles 2..WORDS+1, llc_mem_rsp_valid cycle WORDS+2; next accept earliest cycle WORDS+3.
- No combinational path from any input ready/valid to an output valid; bus_rsp_ready and llc_mem_req_ready depend on state only.

## Test plan
- Write: addr=0x0000010, line=0xDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666 (WORDS=4) -> beats addr 0x100/0x104/0x108/0x10C, wdata 0x77776666, 0x99998888, 0xBBBBAAAA, 0xDDDDCCCC, last only on 4th; ready restored cycle 5.
- Read: addr=0x0000020, bus returns 0x1,0x2,0x3,0x4 -> one beat addr 0x200 write=0 last=1; llc_mem_rsp_line=0x00000004_00000003_00000002_00000001, valid in cycle 6.
- Backpressure: bus_req_ready toggling 1010 during write, llc_mem_rsp_ready held low 5 cycles -> beat fields stable while stalled, no dropped/duplicated beat, rsp line stable until accepted.
- Spurious bus_rsp_valid=1 in IDLE and WR_BEAT -> bus_rsp_ready=0, state and rsp register unchanged.
- Reset asserted after 2nd read data beat -> all outputs to reset values same cycle; following read returns only new data, first word not stale.
- Address wrap: addr = all-ones line address, write -> beat addresses 0xFFFFFFF0..0xFFFFFFFC, no carry into line address.
